// File: rtl/mem_bus_arb.sv
// mem_bus_arb: shares the CPU's single system-bus master port between the
// instruction fetch unit (IFU) and the load/store unit (LSU).
// Each requester gets one pending slot that latches a command pulse. One
// transfer is on the bus at a time, with a request/ack handshake and an
// optional timeout. The stall (busy) signal of a requester stays high until
// its result is delivered.
// Optional feature: define BUSARB_RR_EN to select round-robin arbitration.
// When it is undefined (the default), the LSU has fixed priority over the IFU.
module mem_bus_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TMO_WIDTH  = 8,
    parameter int TMO_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [ADDR_WIDTH-1:0]   i_ifu_addr,
    input  logic                    i_ifu_rd_cmd,
    output logic [DATA_WIDTH-1:0]   o_ifu_dat,
    output logic                    o_ifu_busy,
    output logic                    o_ifu_err_align,
    output logic                    o_ifu_err_bus,
    input  logic [ADDR_WIDTH-1:0]   i_lsu_addr,
    input  logic [DATA_WIDTH-1:0]   i_lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_lsu_be,
    input  logic                    i_lsu_rd_cmd,
    input  logic                    i_lsu_wr_cmd,
    output logic [DATA_WIDTH-1:0]   o_lsu_rdata,
    output logic                    o_lsu_busy,
    output logic                    o_lsu_err_bus,
    output logic [ADDR_WIDTH-1:0]   o_bus_addr,
    output logic [1:0]              o_bus_cmd,
    output logic [DATA_WIDTH-1:0]   o_bus_wdata,
    output logic [DATA_WIDTH/8-1:0] o_bus_be,
    input  logic [DATA_WIDTH-1:0]   i_bus_rdata,
    input  logic                    i_bus_ack,
    input  logic                    i_bus_err
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int BYTE_BITS = $clog2(BE_WIDTH);
    localparam int WADDR_W   = ADDR_WIDTH - BYTE_BITS;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam logic [TMO_WIDTH:0]   TMO_LIMIT = (TMO_WIDTH+1)'(TMO_CYCLES);
    localparam logic [TMO_WIDTH:0]   TMO_STEP  = (TMO_WIDTH+1)'(1);
    localparam logic [TMO_WIDTH-1:0] CNT_STEP  = TMO_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        XFER_IFU,
        XFER_LSU,
        DONE
    } state_t;

    state_t state;

    // IFU pending slot (only word-aligned fetches reach it)
    logic               ifu_pend;
    logic [WADDR_W-1:0] ifu_waddr_q;

    // LSU pending slot
    logic                  lsu_pend;
    logic                  lsu_wr_q;
    logic [WADDR_W-1:0]    lsu_waddr_q;
    logic [DATA_WIDTH-1:0] lsu_wdata_q;
    logic [BE_WIDTH-1:0]   lsu_be_q;

    logic [TMO_WIDTH-1:0] tmo_cnt;

    logic ifu_slot_busy;
    logic lsu_slot_busy;
    logic ifu_accept;
    logic lsu_accept;
    logic ifu_misalign;
    logic lsu_cmd;
    logic can_grant;
    logic grant_ifu;
    logic grant_lsu;
    logic in_xfer;
    logic tmo_hit;
    logic xfer_end;
    logic xfer_fail;

    // The LSU byte offset only matters through the byte enables, so the bus sees the word address.
    logic lsu_offset_unused;
    assign lsu_offset_unused = ^i_lsu_addr[BYTE_BITS-1:0];

    // Command acceptance, stall generation and transfer-completion decode
    always_comb begin
        lsu_cmd       = i_lsu_rd_cmd | i_lsu_wr_cmd;
        ifu_misalign  = |i_ifu_addr[BYTE_BITS-1:0];
        ifu_slot_busy = ifu_pend | (state == XFER_IFU);
        lsu_slot_busy = lsu_pend | (state == XFER_LSU);
        ifu_accept    = i_ifu_rd_cmd & ~ifu_slot_busy;
        lsu_accept    = lsu_cmd & ~lsu_slot_busy;
        o_ifu_busy    = i_ifu_rd_cmd | ifu_slot_busy;
        o_lsu_busy    = lsu_cmd | lsu_slot_busy;
        can_grant     = (state == IDLE) || (state == DONE);
        in_xfer       = (state == XFER_IFU) || (state == XFER_LSU);
        tmo_hit       = (TMO_CYCLES != 0) && (({1'b0, tmo_cnt} + TMO_STEP) == TMO_LIMIT);
        xfer_end      = in_xfer & (i_bus_ack | i_bus_err | tmo_hit);
        xfer_fail     = i_bus_err | (tmo_hit & ~i_bus_ack);
    end

`ifdef BUSARB_RR_EN
    logic last_lsu;

    // Round-robin pick: when both slots are pending, the requester that was not granted last wins.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (can_grant) begin
            if (ifu_pend && lsu_pend) begin
                grant_ifu = last_lsu;
                grant_lsu = ~last_lsu;
            end else begin
                grant_ifu = ifu_pend;
                grant_lsu = lsu_pend;
            end
        end
    end

    // Record the last grant; after reset it counts as an IFU grant, so the LSU wins the first tie.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_lsu <= 1'b0;
        end else if (grant_lsu) begin
            last_lsu <= 1'b1;
        end else if (grant_ifu) begin
            last_lsu <= 1'b0;
        end
    end
`else
    // Fixed pick: the LSU is older in the pipeline, so it always wins to avoid deadlock.
    always_comb begin
        grant_lsu = can_grant & lsu_pend;
        grant_ifu = can_grant & ifu_pend & ~lsu_pend;
    end
`endif

    // Latch IFU fetch commands. Misaligned fetches never reach the bus and only raise a one-cycle alignment error.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ifu_pend        <= 1'b0;
            ifu_waddr_q     <= '0;
            o_ifu_err_align <= 1'b0;
        end else begin
            o_ifu_err_align <= ifu_accept & ifu_misalign;
            if (grant_ifu) begin
                ifu_pend <= 1'b0;
            end else if (ifu_accept && !ifu_misalign) begin
                ifu_pend    <= 1'b1;
                ifu_waddr_q <= i_ifu_addr[ADDR_WIDTH-1:BYTE_BITS];
            end
        end
    end

    // Latch LSU load/store commands. A store wins if both pulses arrive together.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lsu_pend    <= 1'b0;
            lsu_wr_q    <= 1'b0;
            lsu_waddr_q <= '0;
            lsu_wdata_q <= '0;
            lsu_be_q    <= '0;
        end else begin
            if (grant_lsu) begin
                lsu_pend <= 1'b0;
            end else if (lsu_accept) begin
                lsu_pend    <= 1'b1;
                lsu_wr_q    <= i_lsu_wr_cmd;
                lsu_waddr_q <= i_lsu_addr[ADDR_WIDTH-1:BYTE_BITS];
                lsu_wdata_q <= i_lsu_wdata;
                lsu_be_q    <= i_lsu_be;
            end
        end
    end

    // Bus FSM: drive the granted slot onto the bus, wait for ack/err/timeout, and register the result for one DONE cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            o_bus_addr    <= '0;
            o_bus_cmd     <= CMD_IDLE;
            o_bus_wdata   <= '0;
            o_bus_be      <= '0;
            o_ifu_dat     <= '0;
            o_lsu_rdata   <= '0;
            o_ifu_err_bus <= 1'b0;
            o_lsu_err_bus <= 1'b0;
        end else begin
            o_ifu_err_bus <= 1'b0;
            o_lsu_err_bus <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (grant_lsu) begin
                        state       <= XFER_LSU;
                        tmo_cnt     <= '0;
                        o_bus_addr  <= {lsu_waddr_q, {BYTE_BITS{1'b0}}};
                        o_bus_cmd   <= lsu_wr_q ? CMD_WRITE : CMD_READ;
                        o_bus_wdata <= lsu_wdata_q;
                        o_bus_be    <= lsu_be_q;
                    end else if (grant_ifu) begin
                        state       <= XFER_IFU;
                        tmo_cnt     <= '0;
                        o_bus_addr  <= {ifu_waddr_q, {BYTE_BITS{1'b0}}};
                        o_bus_cmd   <= CMD_READ;
                        o_bus_wdata <= '0;
                        o_bus_be    <= {BE_WIDTH{1'b1}};
                    end else begin
                        state     <= IDLE;
                        o_bus_cmd <= CMD_IDLE;
                    end
                end
                XFER_IFU, XFER_LSU: begin
                    tmo_cnt <= tmo_cnt + CNT_STEP;
                    if (xfer_end) begin
                        state     <= DONE;
                        o_bus_cmd <= CMD_IDLE;
                        if (state == XFER_IFU) begin
                            if (xfer_fail) begin
                                o_ifu_err_bus <= 1'b1;
                            end else begin
                                o_ifu_dat <= i_bus_rdata;
                            end
                        end else begin
                            if (xfer_fail) begin
                                o_lsu_err_bus <= 1'b1;
                            end else if (!lsu_wr_q) begin
                                o_lsu_rdata <= i_bus_rdata;
                            end
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_bus_cmd <= CMD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: self-checking bench for mem_bus_arb.
// The bench models a word-addressed memory with byte enables. It derives the
// expected cycle timing of each access from the access latency and the timeout
// limit, and checks the requester and bus sides of the DUT in every cycle.
module tb_mem_bus_arb;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TMO = 4;

    logic          clk;
    logic          nrst;
    logic [AW-1:0] i_ifu_addr;
    logic          i_ifu_rd_cmd;
    logic [DW-1:0] o_ifu_dat;
    logic          o_ifu_busy;
    logic          o_ifu_err_align;
    logic          o_ifu_err_bus;
    logic [AW-1:0] i_lsu_addr;
    logic [DW-1:0] i_lsu_wdata;
    logic [BW-1:0] i_lsu_be;
    logic          i_lsu_rd_cmd;
    logic          i_lsu_wr_cmd;
    logic [DW-1:0] o_lsu_rdata;
    logic          o_lsu_busy;
    logic          o_lsu_err_bus;
    logic [AW-1:0] o_bus_addr;
    logic [1:0]    o_bus_cmd;
    logic [DW-1:0] o_bus_wdata;
    logic [BW-1:0] o_bus_be;
    logic [DW-1:0] i_bus_rdata;
    logic          i_bus_ack;
    logic          i_bus_err;

    mem_bus_arb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TMO_WIDTH (8),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .i_ifu_addr     (i_ifu_addr),
        .i_ifu_rd_cmd   (i_ifu_rd_cmd),
        .o_ifu_dat      (o_ifu_dat),
        .o_ifu_busy     (o_ifu_busy),
        .o_ifu_err_align(o_ifu_err_align),
        .o_ifu_err_bus  (o_ifu_err_bus),
        .i_lsu_addr     (i_lsu_addr),
        .i_lsu_wdata    (i_lsu_wdata),
        .i_lsu_be       (i_lsu_be),
        .i_lsu_rd_cmd   (i_lsu_rd_cmd),
        .i_lsu_wr_cmd   (i_lsu_wr_cmd),
        .o_lsu_rdata    (o_lsu_rdata),
        .o_lsu_busy     (o_lsu_busy),
        .o_lsu_err_bus  (o_lsu_err_bus),
        .o_bus_addr     (o_bus_addr),
        .o_bus_cmd      (o_bus_cmd),
        .o_bus_wdata    (o_bus_wdata),
        .o_bus_be       (o_bus_be),
        .i_bus_rdata    (i_bus_rdata),
        .i_bus_ack      (i_bus_ack),
        .i_bus_err      (i_bus_err)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: memory contents, last delivered load/fetch data, last grant
    logic [31:0] mem [int];
    logic [31:0] exp_ifu_dat;
    logic [31:0] exp_lsu_rdata;
    bit          last_lsu;

    // Bound the whole run so that a stuck bench cannot hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int k;
        k = int'(a >> 2);
        if (mem.exists(k)) return mem[k];
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = mem_rd(a);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = d[8*i +: 8];
        end
        mem[int'(a >> 2)] = w;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a new cycle: just after the rising edge, clear all one-cycle pulses
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        i_ifu_rd_cmd = 1'b0;
        i_lsu_rd_cmd = 1'b0;
        i_lsu_wr_cmd = 1'b0;
        i_bus_ack    = 1'b0;
        i_bus_err    = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit ifu_rd, input logic [31:0] ifu_addr,
                                 input bit lsu_rd, input bit lsu_wr, input logic [31:0] lsu_addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        i_ifu_rd_cmd = ifu_rd;
        if (ifu_rd) i_ifu_addr = ifu_addr;
        i_lsu_rd_cmd = lsu_rd;
        i_lsu_wr_cmd = lsu_wr;
        if (lsu_rd || lsu_wr) begin
            i_lsu_addr  = lsu_addr;
            i_lsu_wdata = wdata;
            i_lsu_be    = be;
        end
    endtask

    // The granted transfer: its bus cycles (ack at cycle lat, or cut off by the timeout), then the DONE cycle
    task automatic xfer_phase(input bit is_ifu, input bit is_wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input int lat, input bit berr, input bit other_busy);
        int          ncyc;
        bit          tmo_exp;
        logic [31:0] rd;
        tmo_exp  = (TMO != 0) && (lat > TMO);
        ncyc     = tmo_exp ? TMO : lat;
        rd       = mem_rd(addr);
        last_lsu = !is_ifu;
        for (int k = 1; k <= ncyc; k++) begin
            begin_cycle();
            if (!tmo_exp && k == lat) begin
                i_bus_ack   = 1'b1;
                i_bus_err   = berr;
                i_bus_rdata = berr ? $urandom : rd;
            end
            sample();
            checkOutput("bus_cmd", o_bus_cmd, is_wr ? 2 : 1);
            checkOutput("bus_addr", o_bus_addr, {addr[31:2], 2'b00});
            if (is_wr) begin
                checkOutput("bus_wdata", o_bus_wdata, wdata);
                checkOutput("bus_be", o_bus_be, be);
            end
            checkOutput("busy_xfer", is_ifu ? o_ifu_busy : o_lsu_busy, 1);
            checkOutput("busy_other_xfer", is_ifu ? o_lsu_busy : o_ifu_busy, other_busy);
            checkOutput("err_quiet", o_ifu_err_bus | o_lsu_err_bus, 0);
        end
        begin_cycle();
        if (tmo_exp) begin
            i_bus_ack   = 1'b1;
            i_bus_rdata = $urandom;
        end
        sample();
        if (!berr && !tmo_exp) begin
            if (is_wr) mem_wr(addr, wdata, be);
            else if (is_ifu) exp_ifu_dat = rd;
            else exp_lsu_rdata = rd;
        end
        checkOutput("bus_cmd_done", o_bus_cmd, 0);
        checkOutput("busy_done", is_ifu ? o_ifu_busy : o_lsu_busy, 0);
        checkOutput("busy_other_done", is_ifu ? o_lsu_busy : o_ifu_busy, other_busy);
        checkOutput("err_bus_own", is_ifu ? o_ifu_err_bus : o_lsu_err_bus, berr || tmo_exp);
        checkOutput("err_bus_other", is_ifu ? o_lsu_err_bus : o_ifu_err_bus, 0);
        checkOutput("ifu_dat", o_ifu_dat, exp_ifu_dat);
        checkOutput("lsu_rdata", o_lsu_rdata, exp_lsu_rdata);
    endtask

    // One uncontended access from command pulse to delivered result
    task automatic access(input bit is_ifu, input bit is_wr, input bit dual, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int lat, input bit berr);
        begin_cycle();
        if (is_ifu) applyStimulus(1'b1, addr, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        else applyStimulus(1'b0, 32'h0, !is_wr || dual, is_wr, addr, wdata, be);
        sample();
        checkOutput("busy_cmd", is_ifu ? o_ifu_busy : o_lsu_busy, 1);
        checkOutput("bus_cmd_idle", o_bus_cmd, 0);
        if (is_ifu && addr[1:0] != 2'b00) begin
            begin_cycle();
            sample();
            checkOutput("err_align", o_ifu_err_align, 1);
            checkOutput("busy_align", o_ifu_busy, 0);
            checkOutput("bus_cmd_align", o_bus_cmd, 0);
            checkOutput("ifu_dat_align", o_ifu_dat, exp_ifu_dat);
            begin_cycle();
            sample();
            checkOutput("err_align_clr", o_ifu_err_align, 0);
            checkOutput("bus_cmd_align2", o_bus_cmd, 0);
        end else begin
            begin_cycle();
            sample();
            checkOutput("busy_grant", is_ifu ? o_ifu_busy : o_lsu_busy, 1);
            checkOutput("bus_cmd_grant", o_bus_cmd, 0);
            checkOutput("err_align_none", o_ifu_err_align, 0);
            xfer_phase(is_ifu, is_wr, addr, wdata, be, lat, berr, 1'b0);
        end
    endtask

    // IFU read and LSU access issued in the same cycle; the arbitration rule decides the order
    task automatic contend(input bit lsu_wr, input logic [31:0] lsu_addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] ifu_addr,
                           input int lat_lsu, input int lat_ifu, input bit berr);
        bit lsu_first;
        begin_cycle();
        applyStimulus(1'b1, ifu_addr, !lsu_wr, lsu_wr, lsu_addr, wdata, be);
        sample();
        checkOutput("busy_both_ifu", o_ifu_busy, 1);
        checkOutput("busy_both_lsu", o_lsu_busy, 1);
        begin_cycle();
        sample();
        checkOutput("busy_both_ifu_g", o_ifu_busy, 1);
        checkOutput("busy_both_lsu_g", o_lsu_busy, 1);
        checkOutput("bus_cmd_both_g", o_bus_cmd, 0);
`ifdef BUSARB_RR_EN
        lsu_first = !last_lsu;
`else
        lsu_first = 1'b1;
`endif
        if (lsu_first) begin
            xfer_phase(1'b0, lsu_wr, lsu_addr, wdata, be, lat_lsu, berr, 1'b1);
            xfer_phase(1'b1, 1'b0, ifu_addr, 32'h0, 4'hF, lat_ifu, 1'b0, 1'b0);
        end else begin
            xfer_phase(1'b1, 1'b0, ifu_addr, 32'h0, 4'hF, lat_ifu, 1'b0, 1'b1);
            xfer_phase(1'b0, lsu_wr, lsu_addr, wdata, be, lat_lsu, berr, 1'b0);
        end
    endtask

    // Assert reset while an LSU read is on the bus; the bus and both stalls must drop at once
    task automatic reset_mid_xfer();
        begin_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        sample();
        begin_cycle();
        sample();
        begin_cycle();
        sample();
        checkOutput("rst_pre_bus_cmd", o_bus_cmd, 1);
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("rst_bus_cmd", o_bus_cmd, 0);
        checkOutput("rst_lsu_busy", o_lsu_busy, 0);
        checkOutput("rst_ifu_busy", o_ifu_busy, 0);
        checkOutput("rst_lsu_rdata", o_lsu_rdata, 0);
        checkOutput("rst_ifu_dat", o_ifu_dat, 0);
        exp_ifu_dat   = 32'h0;
        exp_lsu_rdata = 32'h0;
        last_lsu      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        int          kind;
        int          lat;
        int          lat2;
        bit          berr;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] addr2;
        logic [31:0] wdata;
        logic [3:0]  be;

        nrst          = 1'b0;
        i_ifu_addr    = '0;
        i_ifu_rd_cmd  = 1'b0;
        i_lsu_addr    = '0;
        i_lsu_wdata   = '0;
        i_lsu_be      = '0;
        i_lsu_rd_cmd  = 1'b0;
        i_lsu_wr_cmd  = 1'b0;
        i_bus_rdata   = '0;
        i_bus_ack     = 1'b0;
        i_bus_err     = 1'b0;
        exp_ifu_dat   = 32'h0;
        exp_lsu_rdata = 32'h0;
        last_lsu      = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_bus_cmd", o_bus_cmd, 0);
        checkOutput("reset_bus_addr", o_bus_addr, 0);
        checkOutput("reset_ifu_busy", o_ifu_busy, 0);
        checkOutput("reset_lsu_busy", o_lsu_busy, 0);
        checkOutput("reset_ifu_dat", o_ifu_dat, 0);
        checkOutput("reset_lsu_rdata", o_lsu_rdata, 0);
        checkOutput("reset_errs", {o_ifu_err_align, o_ifu_err_bus, o_lsu_err_bus}, 0);
        nrst = 1'b1;

        $display("[TB] directed accesses");
        mem[int'(32'h100 >> 2)] = 32'hDEADBEEF;
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 2, 1'b0);
        checkOutput("plan_ifu_dat", o_ifu_dat, 32'hDEADBEEF);
        access(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 4'hF, 2, 1'b0);
        access(1'b0, 1'b0, 1'b0, 32'h040, 32'h0, 4'hF, 1, 1'b0);
        contend(1'b1, 32'h200, 32'h12345678, 4'b0011, 32'h104, 2, 3, 1'b0);
        access(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 4'hF, 1, 1'b0);
        checkOutput("plan_merge_low", o_lsu_rdata[15:0], 16'h5678);
        access(1'b0, 1'b0, 1'b0, 32'h080, 32'h0, 4'hF, 2, 1'b1);
        access(1'b0, 1'b0, 1'b0, 32'h0C0, 32'h0, 4'hF, TMO + 2, 1'b0);
        access(1'b1, 1'b0, 1'b0, 32'h0C4, 32'h0, 4'hF, TMO, 1'b0);

        $display("[TB] reset during transfer");
        reset_mid_xfer();
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 1, 1'b0);
        checkOutput("post_reset_ifu_dat", o_ifu_dat, 32'hDEADBEEF);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 3);
            addr  = 32'h400 + ($urandom_range(0, 7) << 2);
            addr2 = 32'h400 + ($urandom_range(0, 7) << 2);
            wdata = $urandom;
            be    = 4'($urandom_range(1, 15));
            lat   = $urandom_range(1, TMO + 2);
            lat2  = $urandom_range(1, TMO + 2);
            berr  = ($urandom_range(0, 4) == 0);
            wr    = $urandom_range(0, 1) != 0;
            case (kind)
                0: begin
                    if ($urandom_range(0, 5) == 0) addr = addr + 32'($urandom_range(1, 3));
                    access(1'b1, 1'b0, 1'b0, addr, 32'h0, 4'hF, lat, berr);
                end
                1: access(1'b0, 1'b0, 1'b0, addr, 32'h0, 4'hF, lat, berr);
                2: access(1'b0, 1'b1, wr, addr + 32'($urandom_range(0, 3)), wdata, be, lat, berr);
                default: contend(wr, addr, wdata, be, addr2, lat, lat2, berr);
            endcase
            repeat ($urandom_range(0, 2)) begin
                begin_cycle();
                sample();
                checkOutput("gap_bus_cmd", o_bus_cmd, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
